hdpldadapt_avmm_cmdfifo_wr: RTL
===============================

HDPLDADAPT_AVMM_CMDFIFO_WR -- requirements
Module: hdpldadapt_avmm_cmdfifo_wr

Interface
REQ-001 Parameters (name, default, meaning): FIFO_DEPTH, 8, command entries (power of two, 4..16).
REQ-002 Parameters: ADDR_WIDTH, 10, command address width.
REQ-003 Parameters: DATA_WIDTH, 8, command write-data width.
REQ-004 Ports (name, direction, width, meaning): avmm_clk, in, 1, the only clock; every flop SHALL be on its rising edge.
REQ-005 avmm_rst, in, 1, reset; this block SHALL use one clock, with an asynchronous active-high reset.
REQ-006 remote_pld_avmm_write / remote_pld_avmm_read, in, 1 each, single-cycle command strobes from the upstream AVMM common interface.
REQ-007 remote_pld_avmm_reg_addr, in, ADDR_WIDTH, command address.
REQ-008 remote_pld_avmm_writedata, in, DATA_WIDTH, command write data.
REQ-009 r_avmm_cmdfifo_pfull_thresh, in, 4, static partial-full threshold; 0 disables pfull.
REQ-010 cmdfifo_pop, in, 1, downstream consumes the head entry.
REQ-011 sticky_clr, in, 1, clears all sticky error flags.
REQ-012 cmdfifo_dout, out, 2+ADDR_WIDTH+DATA_WIDTH, head entry {wr, rd, addr, data}.
REQ-013 cmdfifo_empty / cmdfifo_full, out, 1 each, status flags.
REQ-014 cmdfifo_count, out, 5, current occupancy 0..FIFO_DEPTH.
REQ-015 int_pld_avmm_cmdfifo_wr_pfull, out, 1, partial-full flag returned to the upstream interface.
REQ-016 cmdfifo_ovf / cmdfifo_udf / cmd_conflict, out, 1 each, sticky error flags.

Function
REQ-017 Push condition: write | read in a cycle; each strobe-cycle SHALL be one command.
REQ-018 When write and read are both high, the block SHALL push {wr=1, rd=0, addr, data} and set cmd_conflict.
REQ-019 Storage SHALL be a circular buffer with rd/wr pointers one bit wider than log2(FIFO_DEPTH); wrap SHALL be modulo FIFO_DEPTH.
REQ-020 Show-ahead: cmdfifo_dout SHALL present mem[rd_ptr] whenever cmdfifo_empty=0; the value is don't-care when empty.
REQ-021 Latency: a push at edge N SHALL clear cmdfifo_empty and update cmdfifo_count at N+1; that entry SHALL be visible on cmdfifo_dout in the same cycle.
REQ-022 Pop while not empty SHALL advance rd_ptr at the next edge.
REQ-023 Pop while empty SHALL be ignored and SHALL set cmdfifo_udf.
REQ-024 Push while full without a simultaneous pop SHALL be dropped: no pointer or storage change, and cmdfifo_ovf is set.
REQ-025 Push and pop in the same cycle while full SHALL both be accepted; count SHALL stay FIFO_DEPTH.
REQ-026 Push and pop in the same cycle while empty: the pop SHALL be treated as underflow (udf set); the push SHALL be accepted; count becomes 1.
REQ-027 Push and pop in the same cycle otherwise: count SHALL be unchanged.
REQ-028 Flag definitions: cmdfifo_full = (count == FIFO_DEPTH); cmdfifo_empty = (count == 0); both SHALL be registered.
REQ-029 int_pld_avmm_cmdfifo_wr_pfull SHALL be registered and equal (thresh != 0) & (next_count >= thresh), so it is valid in the same cycle as count.
REQ-030 Thresholds above FIFO_DEPTH SHALL behave as equal to FIFO_DEPTH.
REQ-031 Sticky flags SHALL hold until sticky_clr.
REQ-032 sticky_clr in the same cycle as a new error event: the event SHALL win and the flag SHALL remain 1.
REQ-033 No combinational path SHALL exist from any input to any output except cmdfifo_pop and the pointer state to cmdfifo_dout through the storage read mux.

Reset
REQ-034 On avmm_rst=1 (asynchronous), pointers and count SHALL be 0, cmdfifo_empty=1, and cmdfifo_full=0.
REQ-035 On avmm_rst=1, int_pld_avmm_cmdfifo_wr_pfull=0 and all sticky flags SHALL be 0.
REQ-036 Storage contents need not be reset.
REQ-037 Reset asserted mid-operation SHALL discard all queued commands.
REQ-038 The first push SHALL be accepted on the first rising edge after avmm_rst deasserts.

Verification
REQ-039 Scenario 1: reset, then push write addr=0x123 data=0xA5 -> next cycle empty=0, count=1, dout={1,0,0x123,0xA5}; pop -> empty=1.
REQ-040 Scenario 2: thresh=6, push 6 commands with no pop -> pfull rises in the cycle count=6, full=0; push 2 more -> full=1, count=8.
REQ-041 Scenario 3: full FIFO, push without pop -> ovf=1, count=8, head unchanged; then push and pop together -> count=8, new entry at tail.
REQ-042 Scenario 4: empty FIFO, pop and push together -> udf=1, count=1; sticky_clr -> udf=0.
REQ-043 Scenario 5: write and read strobes high together, addr=0x200 -> entry {1,0,0x200,data}, cmd_conflict=1.
REQ-044 Scenario 6: 5 entries queued, assert avmm_rst asynchronously between edges -> empty=1, count=0, pfull=0 immediately; run 20 push/pop wrap cycles thereafter -> FIFO order preserved.

Source files
------------

// File: rtl/hdpldadapt_avmm_cmdfifo_wr.sv
// Write-side AVMM command FIFO: queues write/read commands from the upstream
// interface in a show-ahead circular buffer with status and sticky error flags.
module hdpldadapt_avmm_cmdfifo_wr #(
  parameter int FIFO_DEPTH = 8,
  parameter int ADDR_WIDTH = 10,
  parameter int DATA_WIDTH = 8
) (
  input  logic                             avmm_clk,
  input  logic                             avmm_rst,
  input  logic                             remote_pld_avmm_write,
  input  logic                             remote_pld_avmm_read,
  input  logic [ADDR_WIDTH-1:0]            remote_pld_avmm_reg_addr,
  input  logic [DATA_WIDTH-1:0]            remote_pld_avmm_writedata,
  input  logic [3:0]                       r_avmm_cmdfifo_pfull_thresh,
  input  logic                             cmdfifo_pop,
  input  logic                             sticky_clr,
  output logic [2+ADDR_WIDTH+DATA_WIDTH-1:0] cmdfifo_dout,
  output logic                             cmdfifo_empty,
  output logic                             cmdfifo_full,
  output logic [4:0]                       cmdfifo_count,
  output logic                             int_pld_avmm_cmdfifo_wr_pfull,
  output logic                             cmdfifo_ovf,
  output logic                             cmdfifo_udf,
  output logic                             cmd_conflict
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int PW = AW + 1;
  localparam int EW = 2 + ADDR_WIDTH + DATA_WIDTH;
  localparam logic [4:0] DEPTH5 = 5'(FIFO_DEPTH);

  logic [EW-1:0] mem [FIFO_DEPTH];

  logic [PW-1:0] wr_ptr_reg, rd_ptr_reg;
  logic [4:0]    count_reg, count_next;
  logic          empty_reg, full_reg, pfull_reg;
  logic          ovf_reg, udf_reg, conflict_reg;

  logic          push_req, push_ok, pop_ok;
  logic          ovf_event, udf_event, conflict_event;
  logic          pfull_next;
  logic [4:0]    thresh_eff;
  logic [EW-1:0] entry;

  // A simultaneous write+read strobe is recorded as a write.
  assign entry = {remote_pld_avmm_write,
                  remote_pld_avmm_read & ~remote_pld_avmm_write,
                  remote_pld_avmm_reg_addr,
                  remote_pld_avmm_writedata};

  assign push_req       = remote_pld_avmm_write | remote_pld_avmm_read;
  assign pop_ok         = cmdfifo_pop & ~empty_reg;
  // When full, a same-cycle pop frees the slot the push needs.
  assign push_ok        = push_req & (~full_reg | pop_ok);
  assign ovf_event      = push_req & full_reg & ~cmdfifo_pop;
  assign udf_event      = cmdfifo_pop & empty_reg;
  assign conflict_event = remote_pld_avmm_write & remote_pld_avmm_read;

  assign count_next = count_reg + 5'(push_ok) - 5'(pop_ok);
  assign thresh_eff = ({1'b0, r_avmm_cmdfifo_pfull_thresh} > DEPTH5) ?
                      DEPTH5 : {1'b0, r_avmm_cmdfifo_pfull_thresh};
  assign pfull_next = (r_avmm_cmdfifo_pfull_thresh != 4'd0) && (count_next >= thresh_eff);

  always_ff @(posedge avmm_clk) begin
    if (push_ok) begin
      mem[wr_ptr_reg[AW-1:0]] <= entry;
    end
  end

  always_ff @(posedge avmm_clk or posedge avmm_rst) begin
    if (avmm_rst) begin
      wr_ptr_reg   <= '0;
      rd_ptr_reg   <= '0;
      count_reg    <= '0;
      empty_reg    <= 1'b1;
      full_reg     <= 1'b0;
      pfull_reg    <= 1'b0;
      ovf_reg      <= 1'b0;
      udf_reg      <= 1'b0;
      conflict_reg <= 1'b0;
    end else begin
      if (push_ok) wr_ptr_reg <= wr_ptr_reg + PW'(1);
      if (pop_ok)  rd_ptr_reg <= rd_ptr_reg + PW'(1);
      count_reg    <= count_next;
      empty_reg    <= (count_next == 5'd0);
      full_reg     <= (count_next == DEPTH5);
      pfull_reg    <= pfull_next;
      // A new error event outranks a same-cycle clear.
      ovf_reg      <= ovf_event      | (ovf_reg      & ~sticky_clr);
      udf_reg      <= udf_event      | (udf_reg      & ~sticky_clr);
      conflict_reg <= conflict_event | (conflict_reg & ~sticky_clr);
    end
  end

  assign cmdfifo_dout                  = mem[rd_ptr_reg[AW-1:0]];
  assign cmdfifo_empty                 = empty_reg;
  assign cmdfifo_full                  = full_reg;
  assign cmdfifo_count                 = count_reg;
  assign int_pld_avmm_cmdfifo_wr_pfull = pfull_reg;
  assign cmdfifo_ovf                   = ovf_reg;
  assign cmdfifo_udf                   = udf_reg;
  assign cmd_conflict                  = conflict_reg;

endmodule
